// File: rtl/doorlock_pkg.sv
// Shared definitions for the keypad code checker.
//   KEY_CLEAR / KEY_ENTER : special keypad codes (0-9 are digits, C-F ignored)
//   state_t               : checker FSM states
//   is_digit()            : true for key codes 0-9
package doorlock_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_CHECK   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/doorlock_digit_buf.sv
// Digit entry buffer: shifts digits in at the LS nibble, counts them and
// flags any digit typed once the buffer is full.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero buffer, count and overflow (wins over digit_en)
//   digit_en   : accept 'digit' this cycle
//   digit      : 4-bit digit value
//   buf_o      : buffered digits, first-entered digit in the MS nibble
//   cnt_o      : digits buffered (0..DIGITS)
//   overflow_o : a digit arrived while the buffer was full
module doorlock_digit_buf #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  digit_en,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   buf_o,
  output logic [3:0]            cnt_o,
  output logic                  overflow_o
);

  localparam int unsigned BW = 4 * DIGITS;

  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (digit_en) begin
      if (cnt_q == 4'(DIGITS)) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = (buf_q << 4) | BW'(digit);
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign buf_o      = buf_q;
  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/doorlock_code_check.sv
// Keypad code checker feeding the door-lock open-time stage.
// Collects digits, compares against the stored code on ENTER, pulses
// unlock / fail / prog_done for one cycle, and locks out all keys for
// 2^LOCK_W cycles after MAX_FAIL consecutive failures. The code may be
// reprogrammed once right after a successful unlock (prog_en high at ENTER).
//   clk, rst   : clock, synchronous active-high reset
//   key_valid  : one-cycle strobe qualifying key_code
//   key_code   : 0-9 digit, A CLEAR, B ENTER, C-F ignored
//   prog_en    : level, sampled at ENTER; requests a code reprogram
//   unlock     : one-cycle pulse on a match (drives open-time stage din)
//   fail       : one-cycle pulse on a rejected check
//   prog_done  : one-cycle pulse when a new code is stored
//   locked_out : high for the whole lockout interval
//   digit_cnt  : digits currently buffered
module doorlock_code_check
  import doorlock_pkg::*;
#(
  parameter int unsigned         DIGITS       = 4,
  parameter int unsigned         MAX_FAIL     = 3,
  parameter int unsigned         LOCK_W       = 28,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       prog_en,
  output logic       unlock,
  output logic       fail,
  output logic       prog_done,
  output logic       locked_out,
  output logic [3:0] digit_cnt
);

  state_t                state_q, state_d;
  logic [2:0]            fail_cnt_q, fail_cnt_d;
  logic                  armed_q, armed_d;
  logic [4*DIGITS-1:0]   code_q, code_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                  prog_q, prog_d;
  logic                  unlock_q, unlock_d;
  logic                  fail_q, fail_d;
  logic                  prog_done_q, prog_done_d;

  logic                  buf_clr;
  logic                  digit_en;
  logic                  fail_hit;
  logic [4*DIGITS-1:0]   entry_buf;
  logic [3:0]            entry_cnt;
  logic                  entry_ovf;
  logic                  entry_valid;

  // The buffer only moves in S_ENTRY, so it holds the latched entry
  // through S_CHECK without a separate copy.
  doorlock_digit_buf #(
    .DIGITS(DIGITS)
  ) u_digit_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (buf_clr),
    .digit_en   (digit_en),
    .digit      (key_code),
    .buf_o      (entry_buf),
    .cnt_o      (entry_cnt),
    .overflow_o (entry_ovf)
  );

  assign entry_valid = (entry_cnt == 4'(DIGITS)) && !entry_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ENTRY;
      fail_cnt_q  <= '0;
      armed_q     <= 1'b0;
      code_q      <= DEFAULT_CODE;
      lock_cnt_q  <= '0;
      prog_q      <= 1'b0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_cnt_q  <= fail_cnt_d;
      armed_q     <= armed_d;
      code_q      <= code_d;
      lock_cnt_q  <= lock_cnt_d;
      prog_q      <= prog_d;
      unlock_q    <= unlock_d;
      fail_q      <= fail_d;
      prog_done_q <= prog_done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    fail_cnt_d  = fail_cnt_q;
    armed_d     = armed_q;
    code_d      = code_q;
    lock_cnt_d  = lock_cnt_q;
    prog_d      = prog_q;
    unlock_d    = 1'b0;
    fail_d      = 1'b0;
    prog_done_d = 1'b0;
    buf_clr     = 1'b0;
    digit_en    = 1'b0;
    fail_hit    = 1'b0;

    unique case (state_q)
      S_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            digit_en = 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            buf_clr = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            prog_d  = prog_en;
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        buf_clr = 1'b1;
        if (prog_q) begin
          if (armed_q && entry_valid) begin
            code_d      = entry_buf;
            prog_done_d = 1'b1;
            armed_d     = 1'b0;
          end else begin
            fail_hit = 1'b1;
          end
        end else if (entry_valid && (entry_buf == code_q)) begin
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          armed_d    = 1'b1;
        end else begin
          fail_hit = 1'b1;
        end

        if (fail_hit) begin
          fail_d  = 1'b1;
          armed_d = 1'b0;
          if (fail_cnt_q < 3'(MAX_FAIL)) begin
            fail_cnt_d = fail_cnt_q + 3'd1;
          end
        end

        if (fail_cnt_d == 3'(MAX_FAIL)) begin
          state_d    = S_LOCKOUT;
          lock_cnt_d = '1;
        end else begin
          state_d = S_ENTRY;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d    = S_ENTRY;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
      end

      default: state_d = S_ENTRY;
    endcase
  end

  // Outputs
  always_comb begin
    unlock     = unlock_q;
    fail       = fail_q;
    prog_done  = prog_done_q;
    locked_out = (state_q == S_LOCKOUT);
    digit_cnt  = entry_cnt;
  end

endmodule
